// File: rtl/bitrev_defs.sv
// Shared definitions for the bit-reverse datapath:
// default word sizes and the serializer FSM state encoding.
package bitrev_defs;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead FIFO, async active-low reset.
// Ports: wr_en/wr_data push, rd_en pops, rd_data is the head word,
// full (registered), empty, count (words held).
module byte_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          do_wr;
  logic          do_rd;

  // Full is taken from the registered state, so a pop never
  // opens a slot for a push in the same cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    unique case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/reversed_byte_serializer.sv
// Buffers reversed bytes in a FIFO and shifts them out bit-serially.
// Ports: byte_in/byte_valid/byte_ready in, bit_out/bit_valid/bit_ready/
// bit_last out, fifo_count occupancy, overflow sticky drop flag.
module reversed_byte_serializer
  import bitrev_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic                          bit_out,
  output logic                          bit_valid,
  input  logic                          bit_ready,
  output logic                          bit_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  ser_state_t            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_inc;
  logic [DATA_WIDTH-1:0] head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
  endfunction

  assign byte_ready = !fifo_full;
  assign push       = byte_valid && byte_ready;
  assign cnt_inc    = cnt + 1'b1;

  assign shifted = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

  byte_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (byte_in),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Pop either to start from idle, or on the accepted last bit
  // so the next frame follows without a bubble.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = !fifo_empty;
      SHIFT:   pop = bit_ready && bit_last && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            state     <= SHIFT;
            shreg     <= head;
            cnt       <= '0;
            bit_out   <= lead_bit(head);
            bit_valid <= 1'b1;
            bit_last  <= (CNT_LAST == '0);
          end
        end
        SHIFT: begin
          if (bit_ready) begin
            if (bit_last) begin
              if (pop) begin
                shreg    <= head;
                cnt      <= '0;
                bit_out  <= lead_bit(head);
                bit_last <= (CNT_LAST == '0);
              end else begin
                state     <= IDLE;
                cnt       <= '0;
                bit_out   <= 1'b0;
                bit_valid <= 1'b0;
                bit_last  <= 1'b0;
              end
            end else begin
              shreg    <= shifted;
              cnt      <= cnt_inc;
              bit_out  <= lead_bit(shifted);
              bit_last <= (cnt_inc == CNT_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (byte_valid && !byte_ready) begin
      overflow <= 1'b1;
    end
  end

endmodule
